// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, an ID-stage copy of the
// fetch-time prediction, resolve-time redirect generation and saturating statistics.
`timescale 1ns/1ps

module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int CNT_WIDTH  = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_en,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  id_flush,
  input  logic                  res_valid,
  input  logic                  res_is_branch,
  input  logic                  res_taken,
  input  logic [ADDR_WIDTH-1:0] res_target,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_INIT  = CNT_ONE << (CNT_WIDTH - 1);
  localparam logic [STAT_WIDTH-1:0] STAT_ONE  = STAT_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX  = {STAT_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_FOUR = ADDR_WIDTH'(4);

  logic                  r_valid [ENTRIES];
  logic [TAG_W-1:0]      r_tag   [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_tgt   [ENTRIES];
  logic [CNT_WIDTH-1:0]  r_cnt   [ENTRIES];

  logic                  r_id_v;
  logic [ADDR_WIDTH-1:0] r_id_pc;
  logic                  r_id_pt;
  logic [ADDR_WIDTH-1:0] r_id_tgt;
  logic                  r_id_hit;

  logic [STAT_WIDTH-1:0] r_stat_br;
  logic [STAT_WIDTH-1:0] r_stat_mp;

  logic [IDX_W-1:0]      w_lk_idx;
  logic [TAG_W-1:0]      w_lk_tag;
  logic                  w_lk_hit;
  logic [IDX_W-1:0]      w_up_idx;
  logic [TAG_W-1:0]      w_up_tag;
  logic                  w_upd;
  logic                  w_wrong;
  logic                  w_do_train;
  logic                  w_do_alloc;
  logic                  w_do_evict;
  logic [CNT_WIDTH-1:0]  w_cnt_cur;
  logic [CNT_WIDTH-1:0]  w_cnt_next;

  // Fetch-side lookup reads the table as it stands before this cycle's update.
  assign w_lk_idx    = if_pc[IDX_W+1:2];
  assign w_lk_tag    = if_pc[ADDR_WIDTH-1:IDX_W+2];
  assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign pred_taken  = w_lk_hit && r_cnt[w_lk_idx][CNT_WIDTH-1];
  assign pred_target = pred_taken ? r_tgt[w_lk_idx] : (if_pc + ADDR_FOUR);

  assign w_up_idx   = r_id_pc[IDX_W+1:2];
  assign w_up_tag   = r_id_pc[ADDR_WIDTH-1:IDX_W+2];
  assign w_upd      = res_valid && r_id_v;
  assign w_do_train = w_upd && res_is_branch && r_id_hit;
  assign w_do_alloc = w_upd && res_is_branch && !r_id_hit && res_taken;
  assign w_do_evict = w_upd && !res_is_branch && r_id_hit;
  assign w_cnt_cur  = r_cnt[w_up_idx];

  // Compare the resolved outcome with what fetch predicted for this instruction.
  always_comb begin
    w_wrong = 1'b0;
    if (res_is_branch) begin
      w_wrong = (res_taken != r_id_pt) ||
                (res_taken && r_id_pt && (res_target != r_id_tgt));
    end else begin
      w_wrong = r_id_pt;
    end
  end

  assign mispredict  = w_upd && w_wrong;
  assign redirect_pc = (res_is_branch && res_taken) ? res_target : (r_id_pc + ADDR_FOUR);

  // Saturating step of the direction counter toward the resolved direction.
  always_comb begin
    w_cnt_next = w_cnt_cur;
    if (res_taken) begin
      if (w_cnt_cur != CNT_MAX) begin
        w_cnt_next = w_cnt_cur + CNT_ONE;
      end else begin
        w_cnt_next = w_cnt_cur;
      end
    end else begin
      if (w_cnt_cur != CNT_ZERO) begin
        w_cnt_next = w_cnt_cur - CNT_ONE;
      end else begin
        w_cnt_next = w_cnt_cur;
      end
    end
  end

  // ID-stage copy of the fetch prediction; a flush wins over an advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_v   <= 1'b0;
      r_id_pc  <= {ADDR_WIDTH{1'b0}};
      r_id_pt  <= 1'b0;
      r_id_tgt <= {ADDR_WIDTH{1'b0}};
      r_id_hit <= 1'b0;
    end else if (id_flush) begin
      r_id_v <= 1'b0;
    end else if (if_en) begin
      r_id_v   <= if_valid;
      r_id_pc  <= if_pc;
      r_id_pt  <= pred_taken;
      r_id_tgt <= pred_target;
      r_id_hit <= w_lk_hit;
    end
  end

  // Entry valid bits and counters: allocate, train or evict the resolved entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_ZERO;
      end
    end else if (w_do_alloc) begin
      r_valid[w_up_idx] <= 1'b1;
      r_cnt[w_up_idx]   <= CNT_INIT;
    end else if (w_do_train) begin
      r_cnt[w_up_idx] <= w_cnt_next;
    end else if (w_do_evict) begin
      r_valid[w_up_idx] <= 1'b0;
    end
  end

  // Tag and target payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_do_alloc) begin
      r_tag[w_up_idx] <= w_up_tag;
      r_tgt[w_up_idx] <= res_target;
    end else if (w_do_train && res_taken) begin
      r_tgt[w_up_idx] <= res_target;
    end
  end

  // Saturating statistics; a clear in the same cycle beats any increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_br <= {STAT_WIDTH{1'b0}};
      r_stat_mp <= {STAT_WIDTH{1'b0}};
    end else if (stat_clr) begin
      r_stat_br <= {STAT_WIDTH{1'b0}};
      r_stat_mp <= {STAT_WIDTH{1'b0}};
    end else begin
      if (w_upd && res_is_branch && (r_stat_br != STAT_MAX)) begin
        r_stat_br <= r_stat_br + STAT_ONE;
      end
      if (mispredict && (r_stat_mp != STAT_MAX)) begin
        r_stat_mp <= r_stat_mp + STAT_ONE;
      end
    end
  end

  assign stat_branches = r_stat_br;
  assign stat_mispred  = r_stat_mp;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus randomized traffic,
// checked against an array-based reference model of the predictor rules.
`timescale 1ns/1ps

module tb_branch_predictor;

  localparam int AW   = 32;
  localparam int EN   = 16;
  localparam int CW   = 2;
  localparam int SW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_en, if_valid, id_flush;
  logic [AW-1:0] if_pc;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          res_valid, res_is_branch, res_taken;
  logic [AW-1:0] res_target;
  logic          mispredict;
  logic [AW-1:0] redirect_pc;
  logic          stat_clr;
  logic [SW-1:0] stat_branches, stat_mispred;

  always #5 clk = ~clk;

  branch_predictor #(.ADDR_WIDTH(AW), .ENTRIES(EN), .CNT_WIDTH(CW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .if_en(if_en), .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .id_flush(id_flush),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
    .res_target(res_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_clr(stat_clr), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  typedef struct {
    int          cyc;
    bit          pt;
    logic [31:0] ptgt;
    bit          mp;
    logic [31:0] rpc;
    int          sb;
    int          sm;
  } exp_t;

  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          cnt;
  } ent_t;

  exp_t        sbq[$];
  ent_t        mt[EN];
  bit          m_id_v, m_id_pt, m_id_hit;
  logic [31:0] m_id_pc, m_id_tgt;
  int          m_sb, m_sm;
  int          cyc_no;
  int          n_pass, n_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc_no, act, want);
  endtask

  task automatic model_reset();
    for (int i = 0; i < EN; i++) begin
      mt[i].v   = 1'b0;
      mt[i].cnt = 0;
    end
    m_id_v = 1'b0; m_id_pt = 1'b0; m_id_hit = 1'b0;
    m_id_pc = 32'd0; m_id_tgt = 32'd0;
    m_sb = 0; m_sm = 0;
  endtask

  // One cycle: drive inputs, queue the expected response, then advance the model.
  task automatic cyc(input bit en, input bit v, input logic [31:0] pc, input bit fl,
                     input bit rv, input bit rb, input bit rt, input logic [31:0] rtg,
                     input bit sc);
    exp_t        e;
    int          idx, ui;
    int unsigned tg;
    bit          hit, pt, mp;
    logic [31:0] ptgt;
    @(negedge clk);
    if_en = en; if_valid = v; if_pc = pc; id_flush = fl;
    res_valid = rv; res_is_branch = rb; res_taken = rt; res_target = rtg; stat_clr = sc;
    cyc_no++;
    idx  = int'((pc / 32'd4) % 32'(EN));
    tg   = pc / (32'd4 * 32'(EN));
    hit  = mt[idx].v && (mt[idx].tag == tg);
    pt   = hit && (mt[idx].cnt >= (1 << (CW - 1)));
    ptgt = pt ? mt[idx].tgt : pc + 32'd4;
    mp   = 1'b0;
    if (rv && m_id_v) begin
      if (rb) mp = (rt != m_id_pt) || (rt && m_id_pt && (rtg != m_id_tgt));
      else    mp = m_id_pt;
    end
    e.cyc = cyc_no; e.pt = pt; e.ptgt = ptgt; e.mp = mp;
    e.rpc = (rb && rt) ? rtg : m_id_pc + 32'd4;
    e.sb  = m_sb; e.sm = m_sm;
    #1;
    sbq.push_back(e);
    if (rv && m_id_v) begin
      ui = int'((m_id_pc / 32'd4) % 32'(EN));
      if (rb && m_id_hit) begin
        if (rt) begin
          mt[ui].cnt = (mt[ui].cnt < CMAX) ? mt[ui].cnt + 1 : CMAX;
          mt[ui].tgt = rtg;
        end else begin
          mt[ui].cnt = (mt[ui].cnt > 0) ? mt[ui].cnt - 1 : 0;
        end
      end else if (rb && rt) begin
        mt[ui].v   = 1'b1;
        mt[ui].tag = m_id_pc / (32'd4 * 32'(EN));
        mt[ui].tgt = rtg;
        mt[ui].cnt = 1 << (CW - 1);
      end else if (!rb && m_id_hit) begin
        mt[ui].v = 1'b0;
      end
    end
    if (sc) begin
      m_sb = 0; m_sm = 0;
    end else begin
      if (rv && m_id_v && rb && m_sb < SMAX) m_sb++;
      if (mp && m_sm < SMAX) m_sm++;
    end
    if (fl) m_id_v = 1'b0;
    else if (en) begin
      m_id_v = v; m_id_pc = pc; m_id_pt = pt; m_id_tgt = ptgt; m_id_hit = hit;
    end
  endtask

  // Monitor: pops one expectation per presented cycle and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("mon_pred_taken",  32'(pred_taken),    32'(e.pt));
        chk("mon_pred_target", pred_target,        e.ptgt);
        chk("mon_mispredict",  32'(mispredict),    32'(e.mp));
        if (e.mp) chk("mon_redirect_pc", redirect_pc, e.rpc);
        chk("mon_stat_branches", 32'(stat_branches), 32'(e.sb));
        chk("mon_stat_mispred",  32'(stat_mispred),  32'(e.sm));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc, rtg;
    n_pass = 0; n_total = 0; cyc_no = 0;
    rst = 1'b1; if_en = 1'b0; if_valid = 1'b0; if_pc = 32'd0; id_flush = 1'b0;
    res_valid = 1'b0; res_is_branch = 1'b0; res_taken = 1'b0; res_target = 32'd0;
    stat_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold lookup and allocation
    cyc(1, 1, 32'h40, 0, 0, 0, 0, 32'h0, 0);
    chk("cold_pt", 32'(pred_taken), 32'd0);
    chk("cold_tgt", pred_target, 32'h44);
    chk("cold_mp", 32'(mispredict), 32'd0);
    chk("cold_sb", 32'(stat_branches), 32'd0);
    cyc(1, 1, 32'h80, 0, 1, 1, 1, 32'h100, 0);
    chk("alloc_mp", 32'(mispredict), 32'd1);
    chk("alloc_rpc", redirect_pc, 32'h100);
    cyc(1, 1, 32'h40, 0, 1, 1, 0, 32'h0, 0);
    chk("alloc_pt", 32'(pred_taken), 32'd1);
    chk("alloc_tgt", pred_target, 32'h100);
    cyc(1, 1, 32'h80, 0, 1, 1, 1, 32'h100, 0);
    chk("alias_pt", 32'(pred_taken), 32'd0);
    chk("alias_tgt", pred_target, 32'h84);
    chk("train_mp", 32'(mispredict), 32'd0);

    // Hysteresis: counter 3 -> 2 -> 1
    cyc(1, 1, 32'h40, 0, 1, 1, 0, 32'h0, 0);
    cyc(1, 1, 32'h40, 0, 1, 1, 1, 32'h100, 0);
    cyc(1, 1, 32'h40, 0, 1, 1, 0, 32'h0, 0);
    chk("hyst_mp", 32'(mispredict), 32'd1);
    chk("hyst_rpc", redirect_pc, 32'h44);
    cyc(1, 1, 32'h40, 0, 1, 1, 0, 32'h0, 0);
    chk("hyst_still_pt", 32'(pred_taken), 32'd1);
    cyc(1, 1, 32'h40, 0, 1, 1, 1, 32'h100, 0);
    chk("hyst_weak_pt", 32'(pred_taken), 32'd0);
    chk("hyst_weak_tgt", pred_target, 32'h44);
    cyc(1, 1, 32'h40, 0, 1, 1, 1, 32'h100, 0);
    chk("dir_mp", 32'(mispredict), 32'd1);

    // Non-branch eviction, stall hold, flush
    cyc(1, 1, 32'h80, 0, 1, 0, 0, 32'h0, 0);
    chk("evict_mp", 32'(mispredict), 32'd1);
    chk("evict_rpc", redirect_pc, 32'h44);
    cyc(1, 1, 32'h40, 0, 0, 0, 0, 32'h0, 0);
    chk("evict_pt", 32'(pred_taken), 32'd0);
    cyc(1, 1, 32'h80, 0, 1, 1, 1, 32'h300, 0);
    cyc(1, 1, 32'h40, 0, 0, 0, 0, 32'h0, 0);
    chk("realloc_tgt", pred_target, 32'h300);
    cyc(0, 1, 32'h80, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 32'h80, 0, 1, 0, 0, 32'h0, 0);
    chk("stall_mp", 32'(mispredict), 32'd1);
    chk("stall_rpc", redirect_pc, 32'h44);
    cyc(1, 1, 32'h80, 1, 0, 0, 0, 32'h0, 0);
    cyc(1, 1, 32'h40, 0, 1, 1, 1, 32'h500, 0);
    chk("flush_mp", 32'(mispredict), 32'd0);

    // Statistics saturation and clear priority
    cyc(1, 1, 32'h1000, 0, 0, 0, 0, 32'h0, 1);
    for (int i = 1; i <= 20; i++)
      cyc(1, 1, 32'h1000 * (i + 1), 0, 1, 1, 1, 32'h2000_0000 + 32'(i * 4), 0);
    cyc(1, 1, 32'h30000, 0, 0, 0, 0, 32'h0, 0);
    chk("sat_sb", 32'(stat_branches), 32'd15);
    chk("sat_sm", 32'(stat_mispred), 32'd15);
    cyc(1, 1, 32'h40, 0, 1, 1, 1, 32'h700, 1);
    chk("clr_mp", 32'(mispredict), 32'd1);
    cyc(1, 1, 32'h80, 0, 0, 0, 0, 32'h0, 0);
    chk("clr_sb", 32'(stat_branches), 32'd0);
    chk("clr_sm", 32'(stat_mispred), 32'd0);
    cyc(1, 1, 32'h40, 0, 1, 1, 1, 32'h900, 0);
    cyc(1, 1, 32'h80, 0, 1, 1, 1, 32'h900, 0);
    chk("pre_rst_pt", 32'(pred_taken), 32'd1);
    chk("pre_rst_mp", 32'(mispredict), 32'd1);
    chk("pre_rst_sb", 32'(stat_branches), 32'd1);

    // Asynchronous reset pulse between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pt", 32'(pred_taken), 32'd0);
    chk("arst_tgt", pred_target, if_pc + 32'd4);
    chk("arst_mp", 32'(mispredict), 32'd0);
    chk("arst_sb", 32'(stat_branches), 32'd0);
    chk("arst_sm", 32'(stat_mispred), 32'd0);
    if_en = 1'b0; res_valid = 1'b0; id_flush = 1'b0; stat_clr = 1'b0;
    rst = 1'b0;
    model_reset();
    cyc(1, 1, 32'h80, 0, 0, 0, 0, 32'h0, 0);
    chk("post_rst_pt80", 32'(pred_taken), 32'd0);
    cyc(1, 1, 32'h40, 0, 1, 1, 0, 32'h0, 0);
    chk("post_rst_pt40", 32'(pred_taken), 32'd0);
    chk("post_rst_mp", 32'(mispredict), 32'd0);

    // Randomized traffic over a small address pool so entries hit and alias
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0)
        rpc = 32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4);
      else
        rpc = 32'($urandom_range(0, 3) * 64 + $urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) rtg = $urandom;
      else rtg = 32'h8000 + 32'($urandom_range(0, 7) * 4);
      cyc($urandom_range(0, 4) != 0, $urandom_range(0, 9) != 0, rpc,
          $urandom_range(0, 9) == 0, $urandom_range(0, 4) < 3,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rtg,
          $urandom_range(0, 29) == 0);
    end

    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
    #3;
    n_total++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d want=0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: instruction address width.
REQ-002 SHALL have parameter ENTRIES, default 16: BTB entry count, power of 2, >=2.
REQ-003 SHALL have parameter CNT_WIDTH, default 2: saturating direction-counter width, >=1.
REQ-004 SHALL have parameter STAT_WIDTH, default 16: statistics counter width.
REQ-005 SHALL have the port `clk`: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have the port `rst`: input, 1 bit, reset, asynchronous and active-high.
REQ-007 SHALL have the port `if_en`: input, 1 bit, IF->ID advance (stall when 0).
REQ-008 SHALL have the port `if_valid`: input, 1 bit, IF holds a real instruction.
REQ-009 SHALL have the port `if_pc`: input, ADDR_WIDTH bits, fetch address.
REQ-010 SHALL have the port `pred_taken`: output, 1 bit, predicted taken for `if_pc`.
REQ-011 SHALL have the port `pred_target`: output, ADDR_WIDTH bits, predicted next PC.
REQ-012 SHALL have the port `id_flush`: input, 1 bit, invalidates the ID-stage prediction copy.
REQ-013 SHALL have the port `res_valid`: input, 1 bit, the ID instruction is resolved this cycle.
REQ-014 SHALL have the port `res_is_branch`: input, 1 bit, the resolved instruction is a branch or jump.
REQ-015 SHALL have the port `res_taken`: input, 1 bit, actual direction.
REQ-016 SHALL have the port `res_target`: input, ADDR_WIDTH bits, actual taken target.
REQ-017 SHALL have the port `mispredict`: output, 1 bit, combinational redirect request.
REQ-018 SHALL have the port `redirect_pc`: output, ADDR_WIDTH bits, correct next PC.
REQ-019 SHALL have the port `stat_clr`: input, 1 bit, synchronous clear of the statistics counters.
REQ-020 SHALL have the ports `stat_branches` and `stat_mispred`: outputs, STAT_WIDTH bits each, statistics counters.

Function
REQ-021 SHALL index the table with IDX=log2(ENTRIES) bits pc[IDX+1:2]; tag = pc[ADDR_WIDTH-1:IDX+2]; each entry holds valid, tag, target, counter.
REQ-022 SHALL compute lookup combinationally: hit = valid & tag match; pred_taken = hit & counter MSB; pred_target = stored target if pred_taken, else if_pc+4 (modulo 2^ADDR_WIDTH).
REQ-023 SHALL update the ID copy (id_v, id_pc, id_pt, id_tgt, id_hit) on each clock edge:
- when id_flush: clear id_v.
- else when if_en: load if_valid, if_pc, pred_taken, pred_target, hit.
- else: hold.
- id_flush has priority over if_en.
REQ-024 SHALL drive mispredict = res_valid & id_v & X, where X is true if any of the following holds:
- res_is_branch & (res_taken != id_pt);
- res_is_branch & res_taken & id_pt & (res_target != id_tgt);
- !res_is_branch & id_pt.
REQ-025 SHALL drive redirect_pc = res_target if (res_is_branch & res_taken), else id_pc+4; value is don't-care when mispredict=0.
REQ-026 SHALL qualify every table update by res_valid & id_v; entry = index of id_pc; updates are written at the clock edge.
REQ-027 SHALL, on a branch that hits:
- counter +1 saturating at 2^CNT_WIDTH-1 if taken, -1 saturating at 0 if not taken;
- target <= res_target if taken.
REQ-028 SHALL, on a taken branch that misses, allocate and overwrite the entry: valid=1, new tag, target=res_target, counter=2^(CNT_WIDTH-1).
REQ-029 SHALL NOT allocate on a not-taken branch that misses.
REQ-030 SHALL clear the valid bit of the entry when a non-branch hits (alias eviction).
REQ-031 SHALL return pre-update contents when a lookup and an update target the same index in the same cycle (read-before-write).
REQ-032 SHALL increment stat_branches on each qualified res_is_branch, and stat_mispred on each mispredict cycle; both saturate at all-ones.
REQ-033 SHALL give stat_clr priority over increments in the same cycle.

Reset
REQ-034 SHALL, on rst=1, immediately (no clock) clear:
- all valid bits and counters;
- id_v, id_pt, id_hit; id_pc and id_tgt to 0;
- both statistics counters.
REQ-035 SHALL therefore hold mispredict=0, pred_taken=0 and pred_target=if_pc+4 while in reset.
REQ-036 SHALL, on rst asserted mid-operation, discard all pending updates; the table state after rst deasserts equals the post-reset state.

Verification (ENTRIES=16, CNT_WIDTH=2)
REQ-037 SHALL cover cold lookup: after reset, if_pc=0x40 -> pred_taken=0, pred_target=0x44.
REQ-038 SHALL cover allocate: ID pc 0x40, taken branch to 0x100, id_pt=0 -> mispredict=1, redirect_pc=0x100; next cycle, lookup 0x40 -> pred_taken=1, pred_target=0x100, counter=2.
REQ-039 SHALL cover aliasing: with 0x40 allocated, lookup 0x80 (same index 0, different tag) -> pred_taken=0, pred_target=0x84.
REQ-040 SHALL cover hysteresis:
- two more taken resolves at 0x40 -> counter=3;
- one not-taken -> mispredict=1, redirect_pc=0x44, counter=2, still predicts taken;
- second not-taken -> counter=1, pred_taken=0.
REQ-041 SHALL cover non-branch eviction: predicted-taken entry at 0x40 resolves as non-branch -> mispredict=1, redirect_pc=0x44, entry invalid next cycle; stall/flush: if_en=0 holds the ID copy, id_flush with if_en=1 gives id_v=0 and mispredict=0.
REQ-042 SHALL cover statistics and reset:
- STAT_WIDTH=4, 20 mispredicting branches -> stat_mispred=15 and stat_branches=15;
- stat_clr together with a mispredict -> both counters 0;
- async rst pulse between clock edges -> outputs cleared without a clock edge.
